// File: rtl/cacheline_burst_adapter_if.sv
// Line-side (cache) and burst-side (memory) signal bundle for cacheline_burst_adapter.
// Optional error_o exists only when BURST_TIMEOUT_EN is defined.
// slave = the adapter's view, master = the cache + memory side that drives it.
interface cacheline_burst_adapter_if #(
  parameter int LINE_WIDTH = 256,
  parameter int BEAT_WIDTH = 64
);
  logic [31:0]             line_address_i;
  logic                    line_read_i;
  logic                    line_write_i;
  logic [LINE_WIDTH-1:0]   line_wdata_i;
  logic [LINE_WIDTH-1:0]   line_rdata_o;
  logic                    line_resp_o;
  logic [31:0]             burst_address_o;
  logic                    burst_read_o;
  logic                    burst_write_o;
  logic [BEAT_WIDTH-1:0]   burst_wdata_o;
  logic [BEAT_WIDTH-1:0]   burst_rdata_i;
  logic                    burst_resp_i;
`ifdef BURST_TIMEOUT_EN
  logic                    error_o;

  modport slave (
    input  line_address_i, line_read_i, line_write_i, line_wdata_i,
    input  burst_rdata_i, burst_resp_i,
    output line_rdata_o, line_resp_o, burst_address_o, burst_read_o,
    output burst_write_o, burst_wdata_o, error_o
  );

  modport master (
    output line_address_i, line_read_i, line_write_i, line_wdata_i,
    output burst_rdata_i, burst_resp_i,
    input  line_rdata_o, line_resp_o, burst_address_o, burst_read_o,
    input  burst_write_o, burst_wdata_o, error_o
  );
`else
  modport slave (
    input  line_address_i, line_read_i, line_write_i, line_wdata_i,
    input  burst_rdata_i, burst_resp_i,
    output line_rdata_o, line_resp_o, burst_address_o, burst_read_o,
    output burst_write_o, burst_wdata_o
  );

  modport master (
    output line_address_i, line_read_i, line_write_i, line_wdata_i,
    output burst_rdata_i, burst_resp_i,
    input  line_rdata_o, line_resp_o, burst_address_o, burst_read_o,
    input  burst_write_o, burst_wdata_o
  );
`endif
endinterface

// File: rtl/cacheline_burst_adapter.sv
// Converts one cacheline fill / write-back into a NUM_BEATS-beat burst; optional watchdog via BURST_TIMEOUT_EN.
// Latency: back-to-back read beats give line_resp_o 6 cycles after the request cycle (IDLE + 4 beats + DONE).
// Backpressure: each beat is held until burst_resp_i; requests are sampled only in IDLE, no queuing.
module cacheline_burst_adapter #(
  parameter int LINE_WIDTH = 256,
  parameter int BEAT_WIDTH = 64
`ifdef BURST_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 1024
`endif
) (
  input logic                      clk,
  input logic                      rst,
  cacheline_burst_adapter_if.slave bus
);

  localparam int NUM_BEATS = LINE_WIDTH / BEAT_WIDTH;
  localparam int CNT_W     = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam int OFF_W     = $clog2(LINE_WIDTH / 8);
  localparam logic [CNT_W-1:0] LAST_BEAT  = CNT_W'(NUM_BEATS - 1);
  localparam logic [31:0]      ALIGN_MASK = ~((32'd1 << OFF_W) - 32'd1);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t                state;
  logic [CNT_W-1:0]      cnt;
  // Holds the write-back line during WRITE and the partially filled line during READ.
  logic [LINE_WIDTH-1:0] line_buf;
  logic [LINE_WIDTH-1:0] line_fill;
  logic                  timed_out;

`ifdef BURST_TIMEOUT_EN
  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [WD_W-1:0] wdog;

  assign timed_out = (wdog == WD_W'(TIMEOUT_CYCLES - 1)) && !bus.burst_resp_i;

  // Count consecutive beat-less burst cycles; any accepted beat or leaving the burst clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdog <= '0;
    end else if ((state == READ || state == WRITE) && !bus.burst_resp_i && !timed_out) begin
      wdog <= wdog + 1'b1;
    end else begin
      wdog <= '0;
    end
  end
`else
  assign timed_out = 1'b0;
`endif

  // Line buffer with the current read beat dropped into its slot.
  always_comb begin
    line_fill = line_buf;
    line_fill[cnt*BEAT_WIDTH +: BEAT_WIDTH] = bus.burst_rdata_i;
  end

  // Write beat follows the counter directly; forced to zero outside WRITE.
  assign bus.burst_wdata_o = (state == WRITE) ? line_buf[cnt*BEAT_WIDTH +: BEAT_WIDTH]
                                               : '0;

  // Main FSM with registered request/response outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state               <= IDLE;
      cnt                 <= '0;
      line_buf            <= '0;
      bus.line_rdata_o    <= '0;
      bus.line_resp_o     <= 1'b0;
      bus.burst_address_o <= '0;
      bus.burst_read_o    <= 1'b0;
      bus.burst_write_o   <= 1'b0;
`ifdef BURST_TIMEOUT_EN
      bus.error_o         <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          // Write-back has priority; a simultaneous read is dropped, not queued.
          if (bus.line_write_i) begin
            line_buf            <= bus.line_wdata_i;
            bus.burst_address_o <= bus.line_address_i & ALIGN_MASK;
            bus.burst_write_o   <= 1'b1;
            state               <= WRITE;
          end else if (bus.line_read_i) begin
            bus.burst_address_o <= bus.line_address_i & ALIGN_MASK;
            bus.burst_read_o    <= 1'b1;
            state               <= READ;
          end
        end
        READ: begin
          if (bus.burst_resp_i) begin
            line_buf <= line_fill;
            cnt      <= cnt + 1'b1;
            if (cnt == LAST_BEAT) begin
              bus.burst_read_o <= 1'b0;
              bus.line_rdata_o <= line_fill;
              bus.line_resp_o  <= 1'b1;
              state            <= DONE;
            end
          end else if (timed_out) begin
            // Abort: complete toward the cache but keep the previous fill line.
            bus.burst_read_o <= 1'b0;
            bus.line_resp_o  <= 1'b1;
            cnt              <= '0;
            state            <= DONE;
`ifdef BURST_TIMEOUT_EN
            bus.error_o      <= 1'b1;
`endif
          end
        end
        WRITE: begin
          if (bus.burst_resp_i) begin
            cnt <= cnt + 1'b1;
            if (cnt == LAST_BEAT) begin
              bus.burst_write_o <= 1'b0;
              bus.line_resp_o   <= 1'b1;
              state             <= DONE;
            end
          end else if (timed_out) begin
            bus.burst_write_o <= 1'b0;
            bus.line_resp_o   <= 1'b1;
            cnt               <= '0;
            state             <= DONE;
`ifdef BURST_TIMEOUT_EN
            bus.error_o       <= 1'b1;
`endif
          end
        end
        DONE: begin
          bus.line_resp_o <= 1'b0;
          state           <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/cacheline_burst_adapter.md
Name: cacheline_burst_adapter

Overview:
Sits directly downstream of the data cache datapath, between its 256-bit line port (pmem_address/pmem_rdata/pmem_wdata/pmem_read/pmem_write/mem_resp) and the 64-bit burst memory interface. It converts one cacheline read or write-back into a 4-beat burst. It presents to the cache a single-cycle completion response together with the assembled line.

Parameters:
LINE_WIDTH, 256, cacheline width in bits
BEAT_WIDTH, 64, burst beat width in bits
NUM_BEATS, LINE_WIDTH/BEAT_WIDTH (4), beats per line (derived; must be a power of 2)
TIMEOUT_CYCLES, 1024, watchdog limit (used only with BURST_TIMEOUT_EN)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
line_address_i  input  32  line address from cache (pmem_address)
line_read_i  input  1  line fill request (pmem_read)
line_write_i  input  1  line write-back request (pmem_write)
line_wdata_i  input  256  write-back line (pmem_wdata)
line_rdata_o  output  256  assembled fill line (to pmem_rdata)
line_resp_o  output  1  one-cycle completion pulse (to mem_resp)
burst_address_o  output  32  line-aligned burst address
burst_read_o  output  1  burst read request
burst_write_o  output  1  burst write request
burst_wdata_o  output  64  current write beat
burst_rdata_i  input  64  current read beat
burst_resp_i  input  1  beat accepted/valid
error_o  output  1  sticky timeout flag (present only with BURST_TIMEOUT_EN)

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state=IDLE, beat counter=0, line_rdata_o=0, line_resp_o=0, burst_read_o=0, burst_write_o=0, burst_address_o=0, burst_wdata_o=0, error_o=0.
- FSM states: IDLE, READ, WRITE, DONE.
- IDLE:
  - Samples requests only in this state.
  - line_write_i=1: latch line_wdata_i into an internal buffer, latch {line_address_i[31:5],5'b0}, counter=0, go to WRITE.
  - Else if line_read_i=1: latch the address the same way and go to READ.
  - Both asserted: write wins; the read is ignored and is not queued.
- READ:
  - burst_read_o=1 (registered; high from the first cycle in READ).
  - Each cycle with burst_resp_i=1: beat slot[counter] <= burst_rdata_i, counter++.
  - Beat 0 maps to bits [63:0]; beat k maps to bits [64k+63:64k].
  - When the beat with counter=NUM_BEATS-1 is accepted: burst_read_o drops next cycle and the state goes to DONE.
- WRITE:
  - burst_write_o=1.
  - burst_wdata_o = buffer slice[counter], combinational from the counter.
  - Each burst_resp_i advances the counter.
  - After the last beat is accepted: burst_write_o drops and the state goes to DONE.
- DONE:
  - line_resp_o=1 for exactly one cycle, then IDLE.
  - line_rdata_o updates only at read completion and holds its value until the next read completes. It is unchanged by writes.
- burst_resp_i in IDLE or DONE is ignored.
- Latency: a read with back-to-back beats takes 1 cycle (IDLE) + 4 beats + 1 (DONE) = 6 cycles from request to line_resp_o.
- The cache must drop its request in the cycle after line_resp_o. A request still high in IDLE starts a new transaction.
- Counter width is log2(NUM_BEATS) bits and wraps to 0 at completion.
- Input changes mid-burst (address, data) are ignored; all values are latched at entry.
- Reset mid-burst:
  - Immediate return to IDLE with all outputs at their reset values.
  - The partial line is discarded and no line_resp_o is issued.

Optional Feature:
BURST_TIMEOUT_EN
- Defined:
  - A watchdog counts consecutive READ/WRITE cycles without burst_resp_i and clears on each beat.
  - When the count reaches TIMEOUT_CYCLES: abort to DONE (line_resp_o pulses), set error_o sticky until rst, and leave line_rdata_o unchanged.
- Undefined: no watchdog and no error_o port; the adapter waits indefinitely.

Test Plan:
1. Read, addr 0x0000_1234, beats 0x11..11, 0x22..22, 0x33..33, 0x44..44, one per cycle -> burst_address_o=0x0000_1220; line_resp_o pulses on cycle 6; line_rdata_o = {0x44..44, 0x33..33, 0x22..22, 0x11..11}.
2. Write-back of line 0xDEAD...BEEF (256-bit pattern), burst_resp_i with 2-cycle gaps -> burst_wdata_o presents slices [63:0] to [255:192] in order, each held until accepted; one line_resp_o after the 4th beat.
3. line_read_i and line_write_i both high in IDLE -> WRITE taken, burst_read_o never asserts, exactly one line_resp_o.
4. rst asserted after beat 2 of a read -> outputs zero asynchronously; the next read completes normally with a correct full line and no stale beats.
5. burst_resp_i pulsed in IDLE and DONE -> counter unchanged; the next read still collects 4 fresh beats.
6. (BURST_TIMEOUT_EN, TIMEOUT_CYCLES=16) read with no burst_resp_i -> line_resp_o at cycle 17 after entering READ, error_o=1 and held until rst, line_rdata_o unchanged.
